nios2_oci_trace_capture: RTL and testbench
==========================================

# nios2_oci_trace_capture

Parametrised capture buffer for the Nios II OCI data-trace (DCT) stream. It records each valid `dct_buffer`/`dct_count` record into a circular store, either stopping or wrapping when full. It honours the bench end-of-test signals `test_ending` and `test_has_ended`, then drains for readout. It sits beside the OCI trace logic and replaces the input-only test-bench stub with a synthesisable, observable capture path.

## Interface
- `WORD_W`, 30, trace word width
- `COUNT_W`, 4, DCT count field width
- `DEPTH`, 16, record slots; power of two, at least 2
- `WRAP_MODE`, 0, when full: 0 = drop new records, 1 = overwrite oldest
- `DROP_W`, 16, width of the saturating drop counter

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `dct_buffer`  in  WORD_W  trace word
- `dct_count`  in  COUNT_W  valid-entry count for the word
- `dct_valid`  in  1  record strobe
- `test_ending`  in  1  end-of-capture request, level
- `test_has_ended`  in  1  test complete, level
- `rd_req`  in  1  pop request
- `rd_valid`  out  1  `rd_word`/`rd_count` valid, one-cycle pulse
- `rd_word`  out  WORD_W  popped word
- `rd_count`  out  COUNT_W  popped count
- `rd_err`  out  1  pulse when `rd_req` arrives while empty
- `level`  out  clog2(DEPTH+1)  stored records
- `overflow`  out  1  sticky; a record was dropped or overwritten
- `drop_cnt`  out  DROP_W  saturating count of dropped or overwritten records
- `state`  out  2  current FSM state
- `done`  out  1  high in DONE

## Operation
- FSM states: CAPTURE=0, DRAIN=1, DONE=2. CAPTURE is entered out of reset.
- CAPTURE goes to DRAIN when `test_ending` or `test_has_ended` is high.
- DRAIN goes to DONE when `test_has_ended` is high and `level` is 0 after any same-cycle pop.
- DONE is terminal until reset.
- A record is written only in CAPTURE when `dct_valid` is high and `dct_count` is nonzero. A zero-count record is ignored and is not counted as a drop.
- A write in the same cycle as the CAPTURE→DRAIN transition is still accepted.
- Full with no pop, `WRAP_MODE=0`: the record is discarded; `overflow` is set; `drop_cnt` increments.
- Full with no pop, `WRAP_MODE=1`: the oldest record is overwritten and the read pointer advances; `overflow` is set; `drop_cnt` increments; `level` stays at DEPTH.
- Full with a same-cycle pop and write: both are performed, with no drop in either mode.
- Pops are allowed in every state.
- `rd_req` while `level` is 0: no pointer change; `rd_err` pulses next cycle.
- Simultaneous push and pop at `level` 0: the pop is an underflow (`rd_err`). The write is still stored, so `level` becomes 1.
- `drop_cnt` saturates at all-ones. `overflow` clears only on reset.
- Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset values:
  - `state`=CAPTURE, `done`=0, `level`=0, `overflow`=0, `drop_cnt`=0
  - `rd_valid`=0, `rd_err`=0, `rd_word`=0, `rd_count`=0
  - both pointers 0
- All outputs are registered.
- Write to readable: 1 cycle. A record written at edge N can be popped by `rd_req` sampled at N+1.
- Read latency: 1 cycle. `rd_req` at edge N gives `rd_valid` with data after edge N+1, held for one cycle only.
- `level`, `overflow` and `drop_cnt` reflect events sampled at edge N from edge N onward.
- State transitions take effect at the sampling edge. `done` rises on the same edge `state` becomes DONE.
- Reset asserted mid-capture or mid-read clears the store immediately; a pending `rd_valid` is suppressed.

## Structure
- Package `nios2_oci_trace_pkg` holds:
  - the state enum (CAPTURE/DRAIN/DONE)
  - `WRAP_MODE` constants (`TRACE_STOP`, `TRACE_WRAP`)
  - a record struct of word plus count
- Sub-module `nios2_oci_trace_ram`: simple dual-port store, DEPTH × (WORD_W+COUNT_W), synchronous write, registered read. It has no reset on contents.
- Pointers, level, FSM and counters live in the top level.

## Test plan
- Reset, then 3 records 0x0000_0001/1, 0x0000_0002/2, 0x0000_0003/3, then 3 pops → `rd_word` 1,2,3 with matching counts; `level` goes 3→0; no `rd_err`.
- `WRAP_MODE=0`, DEPTH=16: write 20 records 1..20 → `level`=16, `drop_cnt`=4, `overflow`=1; pops return 1..16.
- `WRAP_MODE=1`, DEPTH=16: write 20 records 1..20 → `drop_cnt`=4; pops return 5..20.
- Full buffer with simultaneous write and pop → `level` stays 16, `drop_cnt` unchanged. Separately, `dct_count`=0 with `dct_valid` → nothing stored.
- Assert `test_ending` together with a write of 0xAA → 0xAA is stored; a write one cycle later is ignored. Raise `test_has_ended`, pop to empty → `done`=1 on the pop-to-empty edge. An extra pop → `rd_err` pulse.
- Assert `reset_n` low mid-stream with `level`=5 and a pop pending → all outputs reach reset values with no `rd_valid`; capture resumes from CAPTURE.

Source files
------------

// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and constants for the Nios II OCI data-trace capture buffer.
//   trace_state_e : capture FSM states (encoding is visible on the state port)
//   TRACE_STOP/WRAP : full-buffer policy selectors for WRAP_MODE
//   trace_rec_t   : one stored record (trace word plus DCT count) at default widths
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    StCapture = 2'd0,
    StDrain   = 2'd1,
    StDone    = 2'd2
  } trace_state_e;

  // Full-buffer policy: drop the incoming record, or overwrite the oldest one.
  localparam int unsigned TRACE_STOP = 0;
  localparam int unsigned TRACE_WRAP = 1;

  localparam int unsigned TRACE_WORD_W  = 30;
  localparam int unsigned TRACE_COUNT_W = 4;

  typedef struct packed {
    logic [TRACE_WORD_W-1:0]  word;
    logic [TRACE_COUNT_W-1:0] count;
  } trace_rec_t;

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// Simple dual-port record store for the trace capture buffer.
// Synchronous write, registered read; contents are not reset.
// A read and write to the same address in one cycle returns the old contents.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data : write port
//   rd_en   : read strobe,  rd_addr : read address, rd_data : registered read data
module nios2_oci_trace_ram #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned WIDTH  = 34,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Capture buffer for the Nios II OCI data-trace stream.
// Records valid, nonzero-count dct_buffer/dct_count pairs into a circular store while capturing,
// then drains on request once the test signals its end.
//   clk, reset_n            : clock, asynchronous active-low reset
//   dct_buffer/count/valid  : incoming trace record
//   test_ending/has_ended   : end-of-capture and test-complete levels
//   rd_req                  : pop request; rd_valid/rd_word/rd_count return data one cycle later
//   rd_err                  : pop request seen while empty (same latency as rd_valid)
//   level, overflow, drop_cnt, state, done : status
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter  int unsigned WORD_W    = TRACE_WORD_W,
  parameter  int unsigned COUNT_W   = TRACE_COUNT_W,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned WRAP_MODE = TRACE_STOP,
  parameter  int unsigned DROP_W    = 16,
  localparam int unsigned LEVEL_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WORD_W-1:0]  dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic               dct_valid,
  input  logic               test_ending,
  input  logic               test_has_ended,
  input  logic               rd_req,
  output logic               rd_valid,
  output logic [WORD_W-1:0]  rd_word,
  output logic [COUNT_W-1:0] rd_count,
  output logic               rd_err,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic [1:0]         state,
  output logic               done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned REC_W = WORD_W + COUNT_W;

  trace_state_e       state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               done_q;
  logic               pop_q, underflow_q;
  logic               rd_valid_q, rd_err_q;
  logic [WORD_W-1:0]  rd_word_q;
  logic [COUNT_W-1:0] rd_count_q;

  logic             push, pop, underflow, full, empty;
  logic             wr_en, overwrite, drop;
  logic [REC_W-1:0] ram_rdata;

  always_comb begin
    push      = (state_q == StCapture) && dct_valid && (dct_count != '0);
    empty     = (level_q == '0);
    full      = (level_q == LEVEL_W'(DEPTH));
    pop       = rd_req && !empty;
    underflow = rd_req && empty;

    wr_en     = 1'b0;
    overwrite = 1'b0;
    drop      = 1'b0;
    if (push) begin
      if (!full || pop) begin
        wr_en = 1'b1;
      end else if (WRAP_MODE == TRACE_WRAP) begin
        // When full the write pointer equals the read pointer, so this write lands on the
        // oldest record; advancing the read pointer discards it.
        wr_en     = 1'b1;
        overwrite = 1'b1;
        drop      = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = (pop || overwrite) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    if (wr_en && !overwrite && !pop) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (pop && !wr_en) begin
      level_d = level_q - LEVEL_W'(1);
    end

    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCapture: if (test_ending || test_has_ended) state_d = StDrain;
      // Empty is judged after any pop in this same cycle.
      StDrain:   if (test_has_ended && (level_d == '0)) state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StCapture;
    endcase
  end

  nios2_oci_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data ({dct_buffer, dct_count}),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StCapture;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      pop_q       <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_word_q   <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= (state_d == StDone);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      // RAM read data lands one edge after the pop; it is then registered onto the outputs.
      pop_q       <= pop;
      underflow_q <= underflow;
      rd_valid_q  <= pop_q;
      rd_err_q    <= underflow_q;
      if (pop_q) begin
        rd_word_q  <= ram_rdata[REC_W-1:COUNT_W];
        rd_count_q <= ram_rdata[COUNT_W-1:0];
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_word  = rd_word_q;
  assign rd_count = rd_count_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Bench for nios2_oci_trace_capture: drives one stimulus stream into a drop-mode and a
// wrap-mode instance; a queue-based reference model predicts status and pop responses,
// and a monitor checks responses against a scoreboard.
module tb_nios2_oci_trace_capture;
  import nios2_oci_trace_pkg::*;

  localparam int unsigned DEPTH = 16;

  typedef struct {
    bit          err;
    trace_rec_t  rec;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid, test_ending, test_has_ended, rd_req;

  logic        rd_valid_w [2];
  logic [29:0] rd_word_w  [2];
  logic [3:0]  rd_count_w [2];
  logic        rd_err_w   [2];
  logic [4:0]  level_w    [2];
  logic        overflow_w [2];
  logic [15:0] drop_cnt_w [2];
  logic [1:0]  state_w    [2];
  logic        done_w     [2];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  // Reference model, one per instance (0 = drop when full, 1 = overwrite oldest).
  trace_rec_t  store [2][$];
  exp_t        exp_q [2][$];
  int unsigned m_state [2];
  int unsigned m_drops [2];
  bit          m_ovf   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nios2_oci_trace_capture #(
      .WORD_W    (30),
      .COUNT_W   (4),
      .DEPTH     (DEPTH),
      .WRAP_MODE (g),
      .DROP_W    (16)
    ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .dct_valid      (dct_valid),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended),
      .rd_req         (rd_req),
      .rd_valid       (rd_valid_w[g]),
      .rd_word        (rd_word_w[g]),
      .rd_count       (rd_count_w[g]),
      .rd_err         (rd_err_w[g]),
      .level          (level_w[g]),
      .overflow       (overflow_w[g]),
      .drop_cnt       (drop_cnt_w[g]),
      .state          (state_w[g]),
      .done           (done_w[g])
    );
  end

  function automatic string iname(input int m);
    return (m == 0) ? "stop" : "wrap";
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      store[m].delete();
      exp_q[m].delete();
      m_state[m] = 0;
      m_drops[m] = 0;
      m_ovf[m]   = 1'b0;
    end
  endtask

  // Applies the rules for one sampled edge, using the inputs as they were at that edge.
  task automatic model_update();
    trace_rec_t r;
    exp_t       e;
    bit         push;
    for (int m = 0; m < 2; m++) begin
      push = (m_state[m] == 0) && dct_valid && (dct_count != 4'd0);
      if (rd_req) begin
        e.due = cyc + 1;
        if (store[m].size() > 0) begin
          e.err = 1'b0;
          e.rec = store[m].pop_front();
        end else begin
          e.err = 1'b1;
          e.rec = '0;
        end
        exp_q[m].push_back(e);
      end
      if (push) begin
        r.word  = dct_buffer;
        r.count = dct_count;
        if (store[m].size() < DEPTH) begin
          store[m].push_back(r);
        end else begin
          if (m == 1) begin
            void'(store[m].pop_front());
            store[m].push_back(r);
          end
          m_ovf[m] = 1'b1;
          if (m_drops[m] < 65535) m_drops[m]++;
        end
      end
      if (m_state[m] == 0 && (test_ending || test_has_ended)) m_state[m] = 1;
      else if (m_state[m] == 1 && test_has_ended && store[m].size() == 0) m_state[m] = 2;
    end
  endtask

  task automatic check_status();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s level", iname(m)), 32'(level_w[m]), store[m].size());
      check($sformatf("%s overflow", iname(m)), 32'(overflow_w[m]), 32'(m_ovf[m]));
      check($sformatf("%s drop_cnt", iname(m)), 32'(drop_cnt_w[m]), m_drops[m]);
      check($sformatf("%s state", iname(m)), 32'(state_w[m]), m_state[m]);
      check($sformatf("%s done", iname(m)), 32'(done_w[m]), 32'(m_state[m] == 2));
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s %s rd_valid", tag, iname(m)), 32'(rd_valid_w[m]), 0);
      check($sformatf("%s %s rd_err", tag, iname(m)), 32'(rd_err_w[m]), 0);
      check($sformatf("%s %s rd_word", tag, iname(m)), 32'(rd_word_w[m]), 0);
      check($sformatf("%s %s rd_count", tag, iname(m)), 32'(rd_count_w[m]), 0);
      check($sformatf("%s %s level", tag, iname(m)), 32'(level_w[m]), 0);
      check($sformatf("%s %s overflow", tag, iname(m)), 32'(overflow_w[m]), 0);
      check($sformatf("%s %s drop_cnt", tag, iname(m)), 32'(drop_cnt_w[m]), 0);
      check($sformatf("%s %s state", tag, iname(m)), 32'(state_w[m]), 0);
      check($sformatf("%s %s done", tag, iname(m)), 32'(done_w[m]), 0);
    end
  endtask

  task automatic step(input bit v, input logic [29:0] w, input logic [3:0] c, input bit rq);
    @(negedge clk);
    dct_valid  = v;
    dct_buffer = w;
    dct_count  = c;
    rd_req     = rq;
    @(posedge clk);
    #1;
    model_update();
    check_status();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1);
  endtask

  // Scoreboard monitor: every rd_valid/rd_err must match the oldest expected response,
  // on the cycle it is due; a due response that never shows up is also reported.
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      for (int m = 0; m < 2; m++) begin
        if (rd_valid_w[m] || rd_err_w[m]) begin
          if (exp_q[m].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s unexpected response: rd_valid=%0b rd_err=%0b, expected none",
                     iname(m), rd_valid_w[m], rd_err_w[m]);
          end else begin
            mon_e = exp_q[m].pop_front();
            check($sformatf("%s response cycle", iname(m)), cyc, mon_e.due);
            check($sformatf("%s rd_valid", iname(m)), 32'(rd_valid_w[m]), 32'(!mon_e.err));
            check($sformatf("%s rd_err", iname(m)), 32'(rd_err_w[m]), 32'(mon_e.err));
            if (!mon_e.err) begin
              check($sformatf("%s rd_word", iname(m)), 32'(rd_word_w[m]), 32'(mon_e.rec.word));
              check($sformatf("%s rd_count", iname(m)), 32'(rd_count_w[m]),
                    32'(mon_e.rec.count));
            end
          end
        end else if (exp_q[m].size() != 0 && exp_q[m][0].due <= cyc) begin
          mon_e = exp_q[m].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL %s missing response: nothing seen, expected err=%0b word=0x%0h",
                   iname(m), mon_e.err, mon_e.rec.word);
        end
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    dct_buffer     = '0;
    dct_count      = '0;
    dct_valid      = 1'b0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    rd_req         = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;

    // Three records in, three out, in order.
    step(1'b1, 30'd1, 4'd1, 1'b0);
    step(1'b1, 30'd2, 4'd2, 1'b0);
    step(1'b1, 30'd3, 4'd3, 1'b0);
    pops(3);
    idle(3);

    // Twenty records into sixteen slots, then pop everything plus one underflow.
    for (int i = 1; i <= 20; i++) step(1'b1, 30'(i), 4'((i - 1) % 15 + 1), 1'b0);
    pops(17);
    idle(3);

    // Full buffer with simultaneous write and pop; then a zero-count record.
    for (int i = 0; i < 16; i++) step(1'b1, 30'($urandom), 4'($urandom_range(1, 15)), 1'b0);
    step(1'b1, 30'h155, 4'd7, 1'b1);
    step(1'b1, 30'h2AA, 4'd0, 1'b0);
    pops(17);
    idle(3);

    // Randomized mix of writes (including zero counts) and pops.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 30'($urandom), 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 45);
    end
    pops(18);
    idle(3);

    // Reset mid-stream with five records stored and a pop in flight.
    for (int i = 0; i < 5; i++) step(1'b1, 30'(100 + i), 4'(i + 1), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    check_reset_values("midreset hold");
    @(negedge clk);
    dct_valid = 1'b0;
    rd_req    = 1'b0;
    reset_n   = 1'b1;
    step(1'b1, 30'h3000_0001, 4'd9, 1'b0);
    step(1'b1, 30'h3000_0002, 4'd10, 1'b0);
    pops(2);
    idle(3);

    // End of test: write accepted on the transition edge, the next one ignored, then drain.
    test_ending = 1'b1;
    step(1'b1, 30'hAA, 4'd5, 1'b0);
    step(1'b1, 30'hBB, 4'd6, 1'b0);
    test_has_ended = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    pops(1);
    pops(1);
    idle(4);

    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s outstanding responses", iname(m)), exp_q[m].size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
